itf_offchip_ctrl: RTL
=====================

// Module: itf_offchip_ctrl
// PURPOSE
//  Chip-side controller for the off-chip port (pad group IO_Dat/I_/O_Dat*). Loads host-pushed ISA words into CCU.
//  Issues DRAM command words for GLB read/write requests, then streams the data beats in either direction.
//  Drives bus direction (O_DatOE). Sits between the pad ring and CCU/GLB.
// PARAMETERS
//  PORT_WIDTH       128  off-chip data bus width
//  ADDR_WIDTH       16   command length field width
//  DRAM_ADDR_WIDTH  32   DRAM word address width
//  OPNUM            6    number of ISA-consuming modules (O_CfgRdy width)
//  WDT_CYCLES       1024 stall limit, used only with ITF_WATCHDOG_EN
// PORTS
//  clk              in  1            single clock, all logic
//  rst              in  1            async, active-high reset
//  CCUITF_CfgRdy    in  OPNUM        module i ready to take ISA
//  O_CfgRdy         out OPNUM        to pad; registered CCUITF_CfgRdy, zero unless IDLE
//  I_ISAVld         in  1            host marks I_Dat beats as ISA
//  I_DatVld/I_DatLast in 1/1         host beat valid / last beat
//  O_DatRdy         out 1            chip accepts host beat
//  I_Dat            in  PORT_WIDTH   host->chip data (pad input side)
//  O_Dat            out PORT_WIDTH   chip->host data/command (pad output side)
//  O_DatOE          out 1            1 = chip drives bus
//  O_CmdVld/O_DatVld/O_DatLast out 1 command pending / beat valid / last beat
//  I_DatRdy         in  1            host accepts chip beat
//  ITFCCU_IsaDat/Vld out PORT_WIDTH/1; CCUITF_IsaRdy in 1      ISA stream to CCU
//  GLBITF_CmdVld in 1; ITFGLB_CmdRdy out 1                     transfer request
//  GLBITF_CmdDir in 1 (1=chip->DRAM); GLBITF_CmdAddr in DRAM_ADDR_WIDTH; GLBITF_CmdNum in ADDR_WIDTH (beats)
//  GLBITF_Dat/Vld in PORT_WIDTH/1; ITFGLB_Rdy out 1           outbound data from GLB
//  ITFGLB_Dat/Vld out PORT_WIDTH/1; GLBITF_Rdy in 1           inbound data to GLB
//  ITF_Err          out 1            sticky error; cleared only by rst
// BEHAVIOUR
//  Reset: state IDLE; every output 0 (O_DatOE=0 -> bus released); latched cmd and beat count 0.
//  Command word on O_Dat: [0]=Dir, [1+:DRAM_ADDR_WIDTH]=Addr, [1+DRAM_ADDR_WIDTH+:ADDR_WIDTH]=Num-1, rest 0.
//  FSM states IDLE, ISA, CMD, IN2CHIP, OUT2OFF:
//  - IDLE: I_ISAVld&I_DatVld -> ISA; else GLBITF_CmdVld -> latch Dir/Addr/Num, pulse ITFGLB_CmdRdy, go CMD.
//    ISA wins when both arrive in the same cycle; cmd stays pending.
//  - Num==0: accept with a CmdRdy pulse and drop, stay IDLE; no O_CmdVld, no Err.
//  - ISA: O_DatRdy=CCUITF_IsaRdy; ITFCCU_IsaVld=I_DatVld&I_ISAVld; IsaDat=I_Dat combinational pass-through.
//    Handshake with I_DatLast -> IDLE. I_ISAVld drop before last -> Err, -> IDLE.
//  - CMD: O_DatOE=1, O_CmdVld=1, O_DatVld=1, O_Dat=cmd word, all registered.
//    On I_DatRdy -> OUT2OFF if Dir else IN2CHIP; beat count cleared.
//  - IN2CHIP: O_DatOE=0; ITFGLB_Vld=I_DatVld; O_DatRdy=GLBITF_Rdy; count each handshake.
//    Beat Num-1 handshake -> IDLE. I_DatLast on a non-final beat, or absent on the final beat -> Err.
//    The count alone terminates the transfer.
//  - OUT2OFF: O_DatOE=1; O_DatVld=GLBITF_Vld; ITFGLB_Rdy=I_DatRdy; O_Dat=GLBITF_Dat; O_DatLast on beat Num-1.
//    Final handshake -> IDLE, O_DatOE falls the next cycle.
//  O_CmdVld only in CMD. O_CfgRdy forced 0 outside IDLE, so the host cannot start ISA mid-transfer.
//  O_DatOE changes only on state transitions, never within a beat.
//  Zero-bubble streaming: one beat per cycle when both sides are ready. No added latency on data paths.
//  Count width ADDR_WIDTH; Num=2**ADDR_WIDTH-1 is the maximum and the count must not wrap.
//  rst mid-transfer: immediate IDLE, bus released; the host is responsible for aborting its side.
// CONFIGURATION
//  ITF_WATCHDOG_EN defined: in ISA/IN2CHIP/OUT2OFF, count consecutive cycles with no handshake.
//    Reaching WDT_CYCLES -> set Err, force IDLE, release bus.
//  ITF_WATCHDOG_EN undefined: no counter; states wait indefinitely; WDT_CYCLES unused.
// STRUCTURE
//  itf_pkg: state enum, cmd word field offsets/widths (DIR_BIT, ADDR_LSB, NUM_LSB), OPNUM.
//  Sub-module: existing counter instance for the beat count (CLEAR on CMD exit, INC on data handshake).
// TESTING
//  1 ISA load: CfgRdy=6'b000100, host sends 2 beats with I_ISAVld, last on beat 2 -> 2 IsaVld beats, IDLE, O_CfgRdy restored.
//  2 Read: Dir=0, Addr=0x100, Num=4 -> O_Dat[0]=0, [1+:32]=0x100, num field=3.
//    4 beats to GLB, OE=0 during data, IDLE after beat 4, Err=0.
//  3 Write with stall: Dir=1, Num=3, I_DatRdy low 5 cycles mid-burst -> O_DatLast only on beat 3, data order kept, OE drops after.
//  4 Collision: ISA start and CmdVld in the same IDLE cycle -> ISA first, then CMD issued; Num=0 request -> CmdRdy pulse, no O_CmdVld.
//  5 Errors: I_DatLast on beat 2 of Num=4 read -> Err=1, 4 beats still taken.
//    With ITF_WATCHDOG_EN, WDT_CYCLES=16, host silent -> Err at cycle 16, IDLE.
//  6 rst asserted mid OUT2OFF -> next edge all outputs 0, OE=0; new cmd after release completes normally.

Source files
------------

// File: rtl/itf_offchip_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : itf_offchip_ctrl_pkg                                            |
// | Brief    : Shared types and command-word layout for the off-chip port.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package itf_offchip_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISA     = 3'd1,
        ST_CMD     = 3'd2,
        ST_IN2CHIP = 3'd3,
        ST_OUT2OFF = 3'd4
    } itf_state_e;

    localparam int ITF_OPNUM = 6;
    localparam int DIR_BIT   = 0;
    localparam int ADDR_LSB  = 1;

    // Length field sits directly above the DRAM address field.
    function automatic int num_lsb(input int dram_aw);
        return ADDR_LSB + dram_aw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/itf_offchip_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : itf_offchip_ctrl_if                                             |
// | Brief    : Pad, CCU and GLB signal bundle of the off-chip controller.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface itf_offchip_ctrl_if
    import itf_offchip_ctrl_pkg::*;
#(
    parameter int PORT_WIDTH      = 128,
    parameter int ADDR_WIDTH      = 16,
    parameter int DRAM_ADDR_WIDTH = 32,
    parameter int OPNUM           = ITF_OPNUM
);
    logic [OPNUM-1:0]           CCUITF_CfgRdy;
    logic [OPNUM-1:0]           O_CfgRdy;
    logic                       I_ISAVld;
    logic                       I_DatVld;
    logic                       I_DatLast;
    logic                       O_DatRdy;
    logic [PORT_WIDTH-1:0]      I_Dat;
    logic [PORT_WIDTH-1:0]      O_Dat;
    logic                       O_DatOE;
    logic                       O_CmdVld;
    logic                       O_DatVld;
    logic                       O_DatLast;
    logic                       I_DatRdy;
    logic [PORT_WIDTH-1:0]      ITFCCU_IsaDat;
    logic                       ITFCCU_IsaVld;
    logic                       CCUITF_IsaRdy;
    logic                       GLBITF_CmdVld;
    logic                       ITFGLB_CmdRdy;
    logic                       GLBITF_CmdDir;
    logic [DRAM_ADDR_WIDTH-1:0] GLBITF_CmdAddr;
    logic [ADDR_WIDTH-1:0]      GLBITF_CmdNum;
    logic [PORT_WIDTH-1:0]      GLBITF_Dat;
    logic                       GLBITF_Vld;
    logic                       ITFGLB_Rdy;
    logic [PORT_WIDTH-1:0]      ITFGLB_Dat;
    logic                       ITFGLB_Vld;
    logic                       GLBITF_Rdy;
    logic                       ITF_Err;

    modport master (
        input  CCUITF_CfgRdy, I_ISAVld, I_DatVld, I_DatLast, I_Dat, I_DatRdy,
               CCUITF_IsaRdy, GLBITF_CmdVld, GLBITF_CmdDir, GLBITF_CmdAddr,
               GLBITF_CmdNum, GLBITF_Dat, GLBITF_Vld, GLBITF_Rdy,
        output O_CfgRdy, O_DatRdy, O_Dat, O_DatOE, O_CmdVld, O_DatVld, O_DatLast,
               ITFCCU_IsaDat, ITFCCU_IsaVld, ITFGLB_CmdRdy, ITFGLB_Rdy,
               ITFGLB_Dat, ITFGLB_Vld, ITF_Err
    );

    modport slave (
        output CCUITF_CfgRdy, I_ISAVld, I_DatVld, I_DatLast, I_Dat, I_DatRdy,
               CCUITF_IsaRdy, GLBITF_CmdVld, GLBITF_CmdDir, GLBITF_CmdAddr,
               GLBITF_CmdNum, GLBITF_Dat, GLBITF_Vld, GLBITF_Rdy,
        input  O_CfgRdy, O_DatRdy, O_Dat, O_DatOE, O_CmdVld, O_DatVld, O_DatLast,
               ITFCCU_IsaDat, ITFCCU_IsaVld, ITFGLB_CmdRdy, ITFGLB_Rdy,
               ITFGLB_Dat, ITFGLB_Vld, ITF_Err
    );
endinterface
`default_nettype wire

// File: rtl/itf_offchip_ctrl_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : itf_offchip_ctrl_cnt                                            |
// | Brief    : Beat counter with synchronous clear and saturating increment.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module itf_offchip_ctrl_cnt #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clr_i,
    input  wire logic             inc_i,
    output logic [WIDTH-1:0]      cnt_o
);
    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    assign cnt_o = cnt_q;
endmodule
`default_nettype wire

// File: rtl/itf_offchip_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : itf_offchip_ctrl                                                |
// | Brief    : Off-chip port controller: ISA load, DRAM command, data streams. |
// |            Optional stall watchdog enabled by macro ITF_WATCHDOG_EN.       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module itf_offchip_ctrl
    import itf_offchip_ctrl_pkg::*;
#(
    parameter int PORT_WIDTH      = 128,
    parameter int ADDR_WIDTH      = 16,
    parameter int DRAM_ADDR_WIDTH = 32,
    parameter int OPNUM           = ITF_OPNUM
`ifdef ITF_WATCHDOG_EN
    ,
    parameter int WDT_CYCLES      = 1024
`endif
) (
    input  wire logic           clk,
    input  wire logic           rst,
    itf_offchip_ctrl_if.master  bus
);
    localparam int NUM_LSB_L = num_lsb(DRAM_ADDR_WIDTH);

    itf_state_e                 state_q, state_d;
    logic                       dir_q;
    logic [DRAM_ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0]      num_m1_q;
    logic [OPNUM-1:0]           cfgrdy_q;
    logic                       err_q, err_d;
    logic                       w_cmd_load;
    logic [ADDR_WIDTH-1:0]      w_cnt;
    logic                       w_last;
    logic                       w_isa_hs, w_in_hs, w_out_hs;
    logic                       w_wdt_expire;
    logic [PORT_WIDTH-1:0]      w_cmd_word;

    assign w_isa_hs = (state_q == ST_ISA) & bus.I_DatVld & bus.I_ISAVld & bus.CCUITF_IsaRdy;
    assign w_in_hs  = (state_q == ST_IN2CHIP) & bus.I_DatVld & bus.GLBITF_Rdy;
    assign w_out_hs = (state_q == ST_OUT2OFF) & bus.GLBITF_Vld & bus.I_DatRdy;
    assign w_last   = (w_cnt == num_m1_q);

    itf_offchip_ctrl_cnt #(
        .WIDTH (ADDR_WIDTH)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i ((state_q == ST_CMD) & bus.I_DatRdy),
        .inc_i (w_in_hs | w_out_hs),
        .cnt_o (w_cnt)
    );

`ifdef ITF_WATCHDOG_EN
    localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    logic [WDT_W-1:0] wdt_q;
    logic             w_busy;

    assign w_busy       = (state_q == ST_ISA) | (state_q == ST_IN2CHIP) | (state_q == ST_OUT2OFF);
    assign w_wdt_expire = w_busy & ~(w_isa_hs | w_in_hs | w_out_hs)
                        & (wdt_q == WDT_W'(WDT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdt_q <= '0;
        end else if (!w_busy || w_isa_hs || w_in_hs || w_out_hs || w_wdt_expire) begin
            wdt_q <= '0;
        end else begin
            wdt_q <= wdt_q + WDT_W'(1);
        end
    end
`else
    assign w_wdt_expire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            err_q    <= 1'b0;
            dir_q    <= 1'b0;
            addr_q   <= '0;
            num_m1_q <= '0;
            cfgrdy_q <= '0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            cfgrdy_q <= bus.CCUITF_CfgRdy;
            if (w_cmd_load) begin
                dir_q    <= bus.GLBITF_CmdDir;
                addr_q   <= bus.GLBITF_CmdAddr;
                num_m1_q <= bus.GLBITF_CmdNum - ADDR_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        w_cmd_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // ISA has priority; a colliding command stays pending in GLB.
                if (bus.I_ISAVld && bus.I_DatVld) begin
                    state_d = ST_ISA;
                end else if (bus.GLBITF_CmdVld && (bus.GLBITF_CmdNum != '0)) begin
                    w_cmd_load = 1'b1;
                    state_d    = ST_CMD;
                end
            end
            ST_ISA: begin
                if (!bus.I_ISAVld) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (w_isa_hs && bus.I_DatLast) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (bus.I_DatRdy) begin
                    state_d = dir_q ? ST_OUT2OFF : ST_IN2CHIP;
                end
            end
            ST_IN2CHIP: begin
                if (w_in_hs) begin
                    if (bus.I_DatLast != w_last) begin
                        err_d = 1'b1;
                    end
                    if (w_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_OUT2OFF: begin
                if (w_out_hs && w_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (w_wdt_expire) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        w_cmd_word                                  = '0;
        w_cmd_word[DIR_BIT]                         = dir_q;
        w_cmd_word[ADDR_LSB +: DRAM_ADDR_WIDTH]     = addr_q;
        w_cmd_word[NUM_LSB_L +: ADDR_WIDTH]         = num_m1_q;
    end

    always_comb begin
        bus.O_CfgRdy      = '0;
        bus.O_DatRdy      = 1'b0;
        bus.O_Dat         = '0;
        bus.O_DatOE       = 1'b0;
        bus.O_CmdVld      = 1'b0;
        bus.O_DatVld      = 1'b0;
        bus.O_DatLast     = 1'b0;
        bus.ITFCCU_IsaDat = '0;
        bus.ITFCCU_IsaVld = 1'b0;
        bus.ITFGLB_CmdRdy = 1'b0;
        bus.ITFGLB_Rdy    = 1'b0;
        bus.ITFGLB_Dat    = '0;
        bus.ITFGLB_Vld    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.O_CfgRdy      = cfgrdy_q;
                bus.ITFGLB_CmdRdy = bus.GLBITF_CmdVld & ~(bus.I_ISAVld & bus.I_DatVld);
            end
            ST_ISA: begin
                bus.O_DatRdy      = bus.CCUITF_IsaRdy;
                bus.ITFCCU_IsaVld = bus.I_DatVld & bus.I_ISAVld;
                bus.ITFCCU_IsaDat = bus.I_Dat;
            end
            ST_CMD: begin
                bus.O_DatOE  = 1'b1;
                bus.O_CmdVld = 1'b1;
                bus.O_DatVld = 1'b1;
                bus.O_Dat    = w_cmd_word;
            end
            ST_IN2CHIP: begin
                bus.ITFGLB_Vld = bus.I_DatVld;
                bus.ITFGLB_Dat = bus.I_Dat;
                bus.O_DatRdy   = bus.GLBITF_Rdy;
            end
            ST_OUT2OFF: begin
                bus.O_DatOE    = 1'b1;
                bus.O_DatVld   = bus.GLBITF_Vld;
                bus.O_Dat      = bus.GLBITF_Dat;
                bus.O_DatLast  = w_last;
                bus.ITFGLB_Rdy = bus.I_DatRdy;
            end
            default: ;
        endcase
    end

    assign bus.ITF_Err = err_q;
endmodule
`default_nettype wire
